// File: rtl/bus_xfer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// bus_defs : shared definitions for the bus transfer sequencer slice.
//
// Contents
//   - Bus source/destination index map (R0..R15, HI, LO, ZHigh, ZLow, PC,
//     MDR, InPort, C), NUM_BUS_SRC = 24 bus participants.
//   - WRITABLE_MASK : one bit per destination index, 1 when the register has
//     a latch enable. ZHigh/ZLow are loaded by the ALU and InPort/C are
//     input-only, so those four never receive an in_en strobe.
//   - FSM state encoding for the sequencer.
//   - Queued request record and the legality helper used when popping.
// ---------------------------------------------------------------------------
package bus_defs;

  localparam int NUM_BUS_SRC = 24;

  // Bus index map
  localparam logic [4:0] IDX_R0     = 5'd0;
  localparam logic [4:0] IDX_R15    = 5'd15;
  localparam logic [4:0] IDX_HI     = 5'd16;
  localparam logic [4:0] IDX_LO     = 5'd17;
  localparam logic [4:0] IDX_ZHIGH  = 5'd18;
  localparam logic [4:0] IDX_ZLOW   = 5'd19;
  localparam logic [4:0] IDX_PC     = 5'd20;
  localparam logic [4:0] IDX_MDR    = 5'd21;
  localparam logic [4:0] IDX_INPORT = 5'd22;
  localparam logic [4:0] IDX_C      = 5'd23;

  // Bits 18, 19, 22 and 23 are cleared: those registers cannot be latched
  // from the bus.
  localparam logic [NUM_BUS_SRC-1:0] WRITABLE_MASK = 24'h33_FFFF;

  // Sequencer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  // One queued register-transfer request
  typedef struct packed {
    logic [4:0] src;
    logic [4:0] dst;
  } xfer_req_t;

  // A transfer is legal when both indices exist on the bus and the
  // destination has a latch enable.
  function automatic logic xfer_legal(input logic [4:0] src,
                                      input logic [4:0] dst);
    logic ok_v;
    if ((src > IDX_C) || (dst > IDX_C)) begin
      ok_v = 1'b0;
    end else begin
      ok_v = WRITABLE_MASK[dst];
    end
    return ok_v;
  endfunction

endpackage

// File: rtl/decoder5_24.sv
// ---------------------------------------------------------------------------
// decoder5_24 : combinational 5-bit index to 24-bit one-hot decoder.
//
// Ports
//   idx    in  5   bus index (0..23 valid)
//   en     in  1   decoder enable; 0 forces an all-zero output
//   onehot out 24  bit idx set when enabled and idx is in range, else 0
//
// Indices 24..31 decode to all zeros so a corrupted index can never raise
// a stray strobe.
// ---------------------------------------------------------------------------
module decoder5_24
  import bus_defs::*;
(
  input  logic [4:0]             idx,
  input  logic                   en,
  output logic [NUM_BUS_SRC-1:0] onehot
);

  // Range-checked one-hot decode
  always_comb begin
    onehot = {NUM_BUS_SRC{1'b0}};
    if (en && (idx <= IDX_C)) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = {NUM_BUS_SRC{1'b0}};
    end
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// bus_xfer_sequencer : replays queued register transfers as timed one-hot
// bus strobes. Each legal transfer drives exactly one Xout enable and then
// raises exactly one Xin latch enable, so the bus never has two drivers.
//
// Parameters
//   DEPTH  request FIFO entries (power of two, >= 2)
//   CNT_W  width of the completed-transfer counter (wraps)
//
// Ports
//   clk         in   1      system clock, rising edge
//   clr         in   1      asynchronous active-high reset
//   req_valid   in   1      request present
//   req_ready   out  1      FIFO not full; accept on req_valid && req_ready
//   req_src     in   5      source index (bus_defs index map)
//   req_dst     in   5      destination index
//   out_en      out  24     one-hot bus-driver enables
//   in_en       out  24     one-hot latch enables
//   busy        out  1      FSM not idle or FIFO not empty
//   done        out  1      one-cycle pulse on transfer completion
//   err         out  1      one-cycle pulse on rejected transfer
//   xfer_count  out  CNT_W  completed transfers, modulo 2^CNT_W
//
// Build option
//   BUS_XFER_FAST_EN : when defined the DRIVE settle cycle is skipped and a
//   popped legal transfer goes straight to LATCH (one transfer per cycle).
//   When undefined every transfer takes DRIVE then LATCH.
//
// All outputs are registered: the next state and the next transfer indices
// are resolved combinationally and the strobes are decoded from them, so
// the strobes change on the same edge as the state.
// ---------------------------------------------------------------------------
module bus_xfer_sequencer
  import bus_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [4:0]             req_src,
  input  logic [4:0]             req_dst,
  output logic [NUM_BUS_SRC-1:0] out_en,
  output logic [NUM_BUS_SRC-1:0] in_en,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [CNT_W-1:0]       xfer_count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     FILL_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]     FILL_ONE   = (AW+1)'(1);
  localparam logic [AW:0]     FILL_ZERO  = (AW+1)'(0);
  localparam logic [AW-1:0]   PTR_ONE    = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

`ifdef BUS_XFER_FAST_EN
  localparam logic [1:0] ST_ENTRY = ST_LATCH;
`else
  localparam logic [1:0] ST_ENTRY = ST_DRIVE;
`endif

  // FIFO storage and bookkeeping
  xfer_req_t        fifo_mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      fill_r;
  logic [AW:0]      fill_nxt_s;
  logic             req_ready_r;
  logic             push_s;
  logic             pop_s;
  logic             empty_s;
  xfer_req_t        head_s;

  // Sequencer state and current transfer
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [4:0]       cur_src_r;
  logic [4:0]       cur_dst_r;
  logic [4:0]       nxt_src_s;
  logic [4:0]       nxt_dst_s;

  // Decoded strobes for the next cycle
  logic             src_dec_en_s;
  logic             dst_dec_en_s;
  logic [NUM_BUS_SRC-1:0] src_oh_s;
  logic [NUM_BUS_SRC-1:0] dst_oh_s;

  // Registered outputs
  logic [NUM_BUS_SRC-1:0] out_en_r;
  logic [NUM_BUS_SRC-1:0] in_en_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [CNT_W-1:0] xfer_count_r;

  // Ready is registered from the next fill level, so it always equals !full
  // for the current contents and push can never coincide with a full FIFO.
  assign push_s  = req_valid && req_ready_r;
  assign empty_s = (fill_r == FILL_ZERO);
  assign head_s  = fifo_mem_r[rd_ptr_r];

  // Next FIFO occupancy from push/pop
  always_comb begin
    fill_nxt_s = fill_r;
    case ({push_s, pop_s})
      2'b10:   fill_nxt_s = fill_r + FILL_ONE;
      2'b01:   fill_nxt_s = fill_r - FILL_ONE;
      default: fill_nxt_s = fill_r;
    endcase
  end

  // FIFO entry storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= '{src: req_src, dst: req_dst};
    end
  end

  // FIFO pointers, occupancy and ready flag
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      fill_r      <= FILL_ZERO;
      req_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      fill_r      <= fill_nxt_s;
      req_ready_r <= (fill_nxt_s != FILL_FULL);
    end
  end

  // Next-state logic; IDLE, LATCH and ERR share the same pop-and-classify
  // exit so back-to-back transfers have no idle bubble.
  always_comb begin
    pop_s       = 1'b0;
    state_nxt_s = state_r;
    nxt_src_s   = cur_src_r;
    nxt_dst_s   = cur_dst_r;
    case (state_r)
      ST_IDLE, ST_LATCH, ST_ERR: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          nxt_src_s = head_s.src;
          nxt_dst_s = head_s.dst;
          if (xfer_legal(head_s.src, head_s.dst)) begin
            state_nxt_s = ST_ENTRY;
          end else begin
            state_nxt_s = ST_ERR;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        state_nxt_s = ST_LATCH;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Source drives the bus in DRIVE and LATCH; destination latches only in LATCH
  always_comb begin
    src_dec_en_s = (state_nxt_s == ST_DRIVE) || (state_nxt_s == ST_LATCH);
    dst_dec_en_s = (state_nxt_s == ST_LATCH);
  end

  decoder5_24 u_src_dec (
    .idx    (nxt_src_s),
    .en     (src_dec_en_s),
    .onehot (src_oh_s)
  );

  decoder5_24 u_dst_dec (
    .idx    (nxt_dst_s),
    .en     (dst_dec_en_s),
    .onehot (dst_oh_s)
  );

  // State, current transfer and registered outputs
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r      <= ST_IDLE;
      cur_src_r    <= 5'd0;
      cur_dst_r    <= 5'd0;
      out_en_r     <= {NUM_BUS_SRC{1'b0}};
      in_en_r      <= {NUM_BUS_SRC{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      xfer_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      cur_src_r <= nxt_src_s;
      cur_dst_r <= nxt_dst_s;
      out_en_r  <= src_oh_s;
      // The mask is redundant with the ERR path but keeps unwritable
      // latch enables hard-wired low.
      in_en_r   <= dst_oh_s & WRITABLE_MASK;
      busy_r    <= (state_nxt_s != ST_IDLE) || (fill_nxt_s != FILL_ZERO);
      done_r    <= (state_nxt_s == ST_LATCH);
      err_r     <= (state_nxt_s == ST_ERR);
      if (state_nxt_s == ST_LATCH) begin
        xfer_count_r <= xfer_count_r + CNT_ONE;
      end else begin
        xfer_count_r <= xfer_count_r;
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign out_en     = out_en_r;
  assign in_en      = in_en_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;
  assign xfer_count = xfer_count_r;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// Self-checking bench for bus_xfer_sequencer (DEPTH=4, CNT_W=4).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_bus_xfer_sequencer;

  localparam int CNT_W = 4;

`ifdef BUS_XFER_FAST_EN
  localparam int EXP_GAP  = 1;
  localparam bit EXP_FULL = 1'b0;
  localparam int EXP_MID_DONE = 1;
`else
  localparam int EXP_GAP  = 2;
  localparam bit EXP_FULL = 1'b1;
  localparam int EXP_MID_DONE = 0;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_src;
  logic [4:0]       req_dst;
  logic [23:0]      out_en;
  logic [23:0]      in_en;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] xfer_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          done_cyc_q[$];
  logic [23:0] done_out_q[$];
  logic [23:0] done_in_q[$];
  int          err_events;
  int          viol_cnt;
  bit          drv_seen;
  bit          ready_low_seen;

  bus_xfer_sequencer #(.DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .out_en     (out_en),
    .in_en      (in_en),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Event recorder: completions, rejections and strobe-shape violations
  always @(negedge clk) begin
    if (!clr) begin
      if (done) begin
        done_cyc_q.push_back(cyc);
        done_out_q.push_back(out_en);
        done_in_q.push_back(in_en);
      end
      if (err) err_events++;
      if (out_en != 24'd0) drv_seen = 1'b1;
      if (($countones(out_en) > 1) || ($countones(in_en) > 1) ||
          ((in_en != 24'd0) && (out_en == 24'd0)))
        viol_cnt++;
    end
  end

  task automatic do_reset();
    req_valid = 1'b0; req_src = 5'd0; req_dst = 5'd0; clr = 1'b1;
    done_cyc_q.delete(); done_out_q.delete(); done_in_q.delete();
    err_events = 0; viol_cnt = 0; drv_seen = 1'b0; ready_low_seen = 1'b0;
    @(negedge clk); @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic push(input logic [4:0] s, input logic [4:0] d);
    int n = 0;
    req_src = s; req_dst = d; req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 50) begin
      ready_low_seen = 1'b1;
      @(negedge clk); n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL push_timeout ready=%b required 1", req_ready);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_timeout busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; req_valid = 1'b0; req_src = 5'd0; req_dst = 5'd0;
    #3;
    checks++;
    if (out_en !== 24'd0 || in_en !== 24'd0) begin
      errors++; $display("FAIL reset_strobes out=%h in=%h required 0 0", out_en, in_en);
    end
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags done=%b err=%b busy=%b required 0 0 0", done, err, busy);
    end
    checks++;
    if (req_ready !== 1'b1 || xfer_count !== 4'd0) begin
      errors++; $display("FAIL reset_ready_cnt ready=%b cnt=%0d required 1 0", req_ready, xfer_count);
    end
    do_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_en !== 24'd0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL idle_after_reset busy=%b out=%h ready=%b required 0 0 1", busy, out_en, req_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    push(5'd20, 5'd21);
    req_valid = 1'b0;
    checks++;
    if (out_en !== 24'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL single_accept out=%h busy=%b required 0 1", out_en, busy);
    end
`ifndef BUS_XFER_FAST_EN
    @(negedge clk);
    checks++;
    if (out_en !== 24'h10_0000 || in_en !== 24'd0 || done !== 1'b0) begin
      errors++; $display("FAIL single_drive out=%h in=%h done=%b required 100000 0 0", out_en, in_en, done);
    end
`endif
    @(negedge clk);
    checks++;
    if (out_en !== 24'h10_0000 || in_en !== 24'h20_0000 || done !== 1'b1) begin
      errors++; $display("FAIL single_latch out=%h in=%h done=%b required 100000 200000 1", out_en, in_en, done);
    end
    checks++;
    if (xfer_count !== 4'd1) begin
      errors++; $display("FAIL single_count cnt=%0d required 1", xfer_count);
    end
    @(negedge clk);
    checks++;
    if (out_en !== 24'd0 || in_en !== 24'd0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_end out=%h in=%h done=%b busy=%b required 0 0 0 0", out_en, in_en, done, busy);
    end
  endtask

  task automatic test_self_xfer();
    do_reset();
    push(5'd5, 5'd5);
    req_valid = 1'b0;
    wait_idle();
    checks++;
    if (done_q_size() != 1) begin
      errors++; $display("FAIL self_done_count got=%0d required 1", done_q_size());
    end else if (done_out_q[0] !== 24'h00_0020 || done_in_q[0] !== 24'h00_0020) begin
      errors++; $display("FAIL self_strobes out=%h in=%h required 20 20", done_out_q[0], done_in_q[0]);
    end
  endtask

  function automatic int done_q_size();
    return done_cyc_q.size();
  endfunction

  task automatic test_invalid();
    do_reset();
    push(5'd25, 5'd3);
    push(5'd2, 5'd19);
    push(5'd4, 5'd30);
    push(5'd6, 5'd22);
    req_valid = 1'b0;
    wait_idle();
    checks++;
    if (err_events != 4) begin
      errors++; $display("FAIL invalid_err_pulses got=%0d required 4", err_events);
    end
    checks++;
    if (drv_seen !== 1'b0 || done_q_size() != 0) begin
      errors++; $display("FAIL invalid_strobes drv=%b dones=%0d required 0 0", drv_seen, done_q_size());
    end
    checks++;
    if (xfer_count !== 4'd0 || err !== 1'b0) begin
      errors++; $display("FAIL invalid_count cnt=%0d err=%b required 0 0", xfer_count, err);
    end
  endtask

  // Runs a list of legal transfers back to back and checks ordering/spacing
  task automatic run_sequence(input string name, input int n,
                              input logic [4:0] srcs[], input logic [4:0] dsts[]);
    logic [23:0] eo;
    logic [23:0] ei;
    do_reset();
    for (int i = 0; i < n; i++) push(srcs[i], dsts[i]);
    req_valid = 1'b0;
    wait_idle();
    checks++;
    if (done_q_size() != n) begin
      errors++; $display("FAIL %s_done_count got=%0d required %0d", name, done_q_size(), n);
    end else begin
      for (int k = 0; k < n; k++) begin
        eo = 24'd1 << srcs[k];
        ei = 24'd1 << dsts[k];
        checks++;
        if (done_out_q[k] !== eo || done_in_q[k] !== ei) begin
          errors++; $display("FAIL %s_strobes[%0d] out=%h in=%h required %h %h", name, k, done_out_q[k], done_in_q[k], eo, ei);
        end
        if (k > 0) begin
          checks++;
          if (done_cyc_q[k] - done_cyc_q[k-1] != EXP_GAP) begin
            errors++; $display("FAIL %s_gap[%0d] got=%0d required %0d", name, k, done_cyc_q[k] - done_cyc_q[k-1], EXP_GAP);
          end
        end
      end
    end
    checks++;
    if (viol_cnt != 0) begin
      errors++; $display("FAIL %s_onehot violations=%0d required 0", name, viol_cnt);
    end
  endtask

  task automatic test_fill_drain();
    logic [4:0] s[] = new[8];
    logic [4:0] d[] = new[8];
    for (int i = 0; i < 8; i++) begin s[i] = 5'(i); d[i] = 5'(i + 1); end
    run_sequence("fill", 8, s, d);
    checks++;
    if (ready_low_seen !== EXP_FULL) begin
      errors++; $display("FAIL fill_ready_drop got=%b required %b", ready_low_seen, EXP_FULL);
    end
    checks++;
    if (xfer_count !== 4'd8) begin
      errors++; $display("FAIL fill_count cnt=%0d required 8", xfer_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] s[] = '{5'd1, 5'd16, 5'd17};
    logic [4:0] d[] = '{5'd2, 5'd3, 5'd4};
    run_sequence("b2b", 3, s, d);
    checks++;
    if (xfer_count !== 4'd3) begin
      errors++; $display("FAIL b2b_count cnt=%0d required 3", xfer_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) push(5'(i % 16), 5'((i + 1) % 16));
    req_valid = 1'b0;
    wait_idle();
    checks++;
    if (xfer_count !== 4'd1 || done_q_size() != 17) begin
      errors++; $display("FAIL wrap_count cnt=%0d dones=%0d required 1 17", xfer_count, done_q_size());
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int dones_at_clr;
    do_reset();
    push(5'd7, 5'd8);
    req_valid = 1'b0;
    while (out_en === 24'd0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (out_en !== 24'h00_0080) begin
      errors++; $display("FAIL mid_drive out=%h required 80", out_en);
    end
    #2 clr = 1'b1;
    #1;
    dones_at_clr = done_q_size();
    checks++;
    if (out_en !== 24'd0 || in_en !== 24'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear out=%h in=%h busy=%b required 0 0 0", out_en, in_en, busy);
    end
    checks++;
    if (xfer_count !== 4'd0 || req_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL mid_state cnt=%0d ready=%b done=%b required 0 1 0", xfer_count, req_ready, done);
    end
    @(negedge clk);
    clr = 1'b0;
    drv_seen = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (drv_seen !== 1'b0 || busy !== 1'b0 || done_q_size() != EXP_MID_DONE) begin
      errors++; $display("FAIL mid_abandon drv=%b busy=%b dones=%0d required 0 0 %0d", drv_seen, busy, done_q_size(), EXP_MID_DONE);
    end
    checks++;
    if (dones_at_clr != EXP_MID_DONE) begin
      errors++; $display("FAIL mid_no_done dones=%0d required %0d", dones_at_clr, EXP_MID_DONE);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_self_xfer();
    test_invalid();
    test_fill_drain();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
